tcp_tx_ctrl: RTL and testbench
==============================

# tcp_tx_ctrl

Control FSM that sequences `tcp_tx_datap` for one scheduler request at a time. It accepts a request from the TX scheduler and issues the state and tuple reads. It pulses the datapath store strobes, then drains three outputs: the packet header, the next-TX-state write and the scheduler update command. It sits beside `tcp_tx_datap` inside `tcp_tx_pipe` and owns every valid/ready handshake that the datapath lacks.

## Interface
Parameters:
- `CNT_W`, 32, width of the packet statistics counters.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sched_tx_req_val` in 1 / `sched_tx_req_rdy` out 1: scheduler request handshake.
- `state_rd_req_val` out 1 / `state_rd_req_rdy` in 1: combined tail-ptr, curr-TX-state and RX-state read request.
- `state_rd_resp_val` in 1 / `state_rd_resp_rdy` out 1: combined state read response.
- `tuple_rd_req_val` out 1 / `tuple_rd_req_rdy` in 1: tuple read request.
- `tuple_rd_resp_val` in 1 / `tuple_rd_resp_rdy` out 1: tuple read response.
- `ctrl_datap_store_flowid`, `ctrl_datap_store_state`, `ctrl_datap_store_tuple`, `ctrl_datap_store_calc` out 1 each: datapath load strobes.
- `datap_ctrl_produce_pkt` in 1: datapath decision that a packet is needed.
- `next_tx_state_wr_req_val` out 1 / `next_tx_state_wr_req_rdy` in 1: next-TX-state write handshake.
- `tx_sched_update_val` out 1 / `tx_sched_update_rdy` in 1: scheduler update command handshake.
- `proto_calc_tx_pkt_val` out 1 / `proto_calc_tx_pkt_rdy` in 1: header/payload descriptor handshake toward the assembler.
- `pkt_sent_cnt` out CNT_W: packets handed downstream.
- `pkt_suppressed_cnt` out CNT_W: requests that produced no packet.

## Operation
- States: IDLE, READ, CALC, OUTPUT.
- **IDLE**
  - `sched_tx_req_rdy` = 1.
  - On `val & rdy`: pulse `store_flowid`, clear the done flags, go to READ.
- **READ**
  - Four done flags: `st_req`, `tp_req`, `st_resp`, `tp_resp`.
  - Each request valid is asserted until its flag sets.
  - A response ready is asserted only once its request was accepted and until its response flag sets.
  - `store_state` pulses on the state-response handshake cycle. `store_tuple` pulses on the tuple-response handshake cycle.
  - All four flags set, or the final handshake completing this cycle: go to CALC.
- **CALC**
  - Pulse `store_calc` for exactly 1 cycle, then go to OUTPUT.
- **OUTPUT**
  - Three done flags: `pkt`, `wr`, `upd`.
  - `next_tx_state_wr_req_val` and `tx_sched_update_val` are asserted until their handshakes complete.
  - `proto_calc_tx_pkt_val` = `datap_ctrl_produce_pkt` until its handshake. When `produce_pkt` = 0, the `pkt` flag counts as done.
  - All three done: increment `pkt_sent_cnt` if a packet was sent, otherwise `pkt_suppressed_cnt`. Go to IDLE.
- Counters wrap modulo 2^CNT_W.
- Simultaneous handshakes in one cycle are all honoured.
- Once asserted, a valid stays high until its handshake completes.

## Timing
- Reset values:
  - FSM = IDLE, all flags 0, counters 0.
  - `sched_tx_req_rdy` = 1, all other outputs 0.
- Reset mid-operation aborts the transaction; no write or update is emitted for it.
- Zero-wait case (every rdy = 1, 1-cycle memory response):
  - accept at cycle 0;
  - reads at cycle 1;
  - responses at cycle 2;
  - `store_calc` at cycle 3;
  - outputs at cycle 4;
  - back in IDLE at cycle 5, next accept at cycle 5.
- Minimum request period is 5 cycles.
- Responses may arrive in either order or in the same cycle.
- A response is never accepted before its request.
- Memories hold `resp_val` while `resp_rdy` is low.
- `datap_ctrl_produce_pkt` is sampled only in OUTPUT. It is valid there because the datapath registers load on `store_calc`.
- No new request is accepted outside IDLE.

## Structure
- `tcp_pkg` holds `tcp_tx_ctrl_state_e` (2-bit enum: IDLE, READ, CALC, OUTPUT).
- Done flags and counters are local to this block.
- No sub-module; a single FSM plus flag registers.
- `tcp_tx_pipe` instantiates this block with `tcp_tx_datap`.

## Test plan
- **Zero-wait request with `produce_pkt` = 1:** store strobes occur in order flowid@0, state/tuple@2, calc@3; pkt, wr and upd handshakes @4; `pkt_sent_cnt` = 1; `sched_tx_req_rdy` is high again @5.
- **`produce_pkt` = 0:** no `proto_calc_tx_pkt_val`; wr and upd still complete; `pkt_suppressed_cnt` = 1.
- **Tuple response 3 cycles before state response, with `state_rd_req_rdy` low for 2 cycles:** each store pulses exactly once; CALC is entered 1 cycle after the last response.
- **`proto_calc_tx_pkt_rdy` low for 4 cycles, `tx_sched_update_rdy` low for 1 cycle:** each valid stays high until its own handshake; the return to IDLE follows the last handshake.
- **`rst_n` asserted in OUTPUT mid-stall:** all valids drop asynchronously and counters clear; the next request starts cleanly.
- **Counters preset to 2^CNT_W−1:** the next sent packet wraps `pkt_sent_cnt` to 0.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared types for the TCP transmit pipeline control logic.
package tcp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    CALC   = 2'd2,
    OUTPUT = 2'd3
  } tcp_tx_ctrl_state_e;

endpackage

// File: rtl/tcp_tx_ctrl_if.sv
// Handshake and datapath-strobe bundle between tcp_tx_ctrl and its surroundings.
interface tcp_tx_ctrl_if;

  logic sched_tx_req_val;
  logic sched_tx_req_rdy;
  logic state_rd_req_val;
  logic state_rd_req_rdy;
  logic state_rd_resp_val;
  logic state_rd_resp_rdy;
  logic tuple_rd_req_val;
  logic tuple_rd_req_rdy;
  logic tuple_rd_resp_val;
  logic tuple_rd_resp_rdy;
  logic ctrl_datap_store_flowid;
  logic ctrl_datap_store_state;
  logic ctrl_datap_store_tuple;
  logic ctrl_datap_store_calc;
  logic datap_ctrl_produce_pkt;
  logic next_tx_state_wr_req_val;
  logic next_tx_state_wr_req_rdy;
  logic tx_sched_update_val;
  logic tx_sched_update_rdy;
  logic proto_calc_tx_pkt_val;
  logic proto_calc_tx_pkt_rdy;

  // master is the control FSM; slave is the scheduler/memories/datapath side
  modport master (
    input  sched_tx_req_val,  output sched_tx_req_rdy,
    output state_rd_req_val,  input  state_rd_req_rdy,
    input  state_rd_resp_val, output state_rd_resp_rdy,
    output tuple_rd_req_val,  input  tuple_rd_req_rdy,
    input  tuple_rd_resp_val, output tuple_rd_resp_rdy,
    output ctrl_datap_store_flowid, output ctrl_datap_store_state,
    output ctrl_datap_store_tuple,  output ctrl_datap_store_calc,
    input  datap_ctrl_produce_pkt,
    output next_tx_state_wr_req_val, input next_tx_state_wr_req_rdy,
    output tx_sched_update_val,      input tx_sched_update_rdy,
    output proto_calc_tx_pkt_val,    input proto_calc_tx_pkt_rdy
  );

  modport slave (
    output sched_tx_req_val,  input  sched_tx_req_rdy,
    input  state_rd_req_val,  output state_rd_req_rdy,
    output state_rd_resp_val, input  state_rd_resp_rdy,
    input  tuple_rd_req_val,  output tuple_rd_req_rdy,
    output tuple_rd_resp_val, input  tuple_rd_resp_rdy,
    input  ctrl_datap_store_flowid, input ctrl_datap_store_state,
    input  ctrl_datap_store_tuple,  input ctrl_datap_store_calc,
    output datap_ctrl_produce_pkt,
    input  next_tx_state_wr_req_val, output next_tx_state_wr_req_rdy,
    input  tx_sched_update_val,      output tx_sched_update_rdy,
    input  proto_calc_tx_pkt_val,    output proto_calc_tx_pkt_rdy
  );

endinterface

// File: rtl/tcp_tx_ctrl.sv
// Sequences one scheduler request through state/tuple reads, the datapath
// calculation strobe and the three output handshakes, counting sent/suppressed packets.
module tcp_tx_ctrl
  import tcp_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  tcp_tx_ctrl_if.master    bus,
  output logic [CNT_W-1:0] pkt_sent_cnt,
  output logic [CNT_W-1:0] pkt_suppressed_cnt
);

  tcp_tx_ctrl_state_e state_q, state_d;
  logic st_req_q, st_req_d, tp_req_q, tp_req_d;
  logic st_resp_q, st_resp_d, tp_resp_q, tp_resp_d;
  logic pkt_q, pkt_d, wr_q, wr_d, upd_q, upd_d;
  logic [CNT_W-1:0] sent_q, sent_d, supp_q, supp_d;

  logic req_rdy, st_req_val, tp_req_val, st_resp_rdy, tp_resp_rdy;
  logic pkt_val, wr_val, upd_val;
  logic store_flowid, store_state, store_tuple, store_calc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      st_req_q  <= 1'b0;
      tp_req_q  <= 1'b0;
      st_resp_q <= 1'b0;
      tp_resp_q <= 1'b0;
      pkt_q     <= 1'b0;
      wr_q      <= 1'b0;
      upd_q     <= 1'b0;
      sent_q    <= '0;
      supp_q    <= '0;
    end else begin
      state_q   <= state_d;
      st_req_q  <= st_req_d;
      tp_req_q  <= tp_req_d;
      st_resp_q <= st_resp_d;
      tp_resp_q <= tp_resp_d;
      pkt_q     <= pkt_d;
      wr_q      <= wr_d;
      upd_q     <= upd_d;
      sent_q    <= sent_d;
      supp_q    <= supp_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    st_req_d     = st_req_q;
    tp_req_d     = tp_req_q;
    st_resp_d    = st_resp_q;
    tp_resp_d    = tp_resp_q;
    pkt_d        = pkt_q;
    wr_d         = wr_q;
    upd_d        = upd_q;
    sent_d       = sent_q;
    supp_d       = supp_q;
    req_rdy      = 1'b0;
    st_req_val   = 1'b0;
    tp_req_val   = 1'b0;
    st_resp_rdy  = 1'b0;
    tp_resp_rdy  = 1'b0;
    pkt_val      = 1'b0;
    wr_val       = 1'b0;
    upd_val      = 1'b0;
    store_flowid = 1'b0;
    store_state  = 1'b0;
    store_tuple  = 1'b0;
    store_calc   = 1'b0;

    case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (bus.sched_tx_req_val) begin
          store_flowid = 1'b1;
          st_req_d     = 1'b0;
          tp_req_d     = 1'b0;
          st_resp_d    = 1'b0;
          tp_resp_d    = 1'b0;
          pkt_d        = 1'b0;
          wr_d         = 1'b0;
          upd_d        = 1'b0;
          state_d      = READ;
        end
      end
      READ: begin
        st_req_val  = ~st_req_q;
        tp_req_val  = ~tp_req_q;
        // a response is only taken once the matching request has been accepted
        st_resp_rdy = st_req_q & ~st_resp_q;
        tp_resp_rdy = tp_req_q & ~tp_resp_q;
        store_state = st_resp_rdy & bus.state_rd_resp_val;
        store_tuple = tp_resp_rdy & bus.tuple_rd_resp_val;
        st_req_d    = st_req_q | (st_req_val & bus.state_rd_req_rdy);
        tp_req_d    = tp_req_q | (tp_req_val & bus.tuple_rd_req_rdy);
        st_resp_d   = st_resp_q | store_state;
        tp_resp_d   = tp_resp_q | store_tuple;
        if (st_req_d & tp_req_d & st_resp_d & tp_resp_d) begin
          state_d = CALC;
        end
      end
      CALC: begin
        store_calc = 1'b1;
        state_d    = OUTPUT;
      end
      OUTPUT: begin
        pkt_val = bus.datap_ctrl_produce_pkt & ~pkt_q;
        wr_val  = ~wr_q;
        upd_val = ~upd_q;
        pkt_d   = pkt_q | (pkt_val & bus.proto_calc_tx_pkt_rdy);
        wr_d    = wr_q | (wr_val & bus.next_tx_state_wr_req_rdy);
        upd_d   = upd_q | (upd_val & bus.tx_sched_update_rdy);
        // with no packet wanted the pkt leg is already complete
        if ((pkt_d | ~bus.datap_ctrl_produce_pkt) & wr_d & upd_d) begin
          state_d = IDLE;
          if (pkt_d) begin
            sent_d = sent_q + CNT_W'(1);
          end else begin
            supp_d = supp_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sched_tx_req_rdy         = req_rdy;
  assign bus.state_rd_req_val         = st_req_val;
  assign bus.tuple_rd_req_val         = tp_req_val;
  assign bus.state_rd_resp_rdy        = st_resp_rdy;
  assign bus.tuple_rd_resp_rdy        = tp_resp_rdy;
  assign bus.ctrl_datap_store_flowid  = store_flowid;
  assign bus.ctrl_datap_store_state   = store_state;
  assign bus.ctrl_datap_store_tuple   = store_tuple;
  assign bus.ctrl_datap_store_calc    = store_calc;
  assign bus.proto_calc_tx_pkt_val    = pkt_val;
  assign bus.next_tx_state_wr_req_val = wr_val;
  assign bus.tx_sched_update_val      = upd_val;
  assign pkt_sent_cnt                 = sent_q;
  assign pkt_suppressed_cnt           = supp_q;

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// Randomised bench for tcp_tx_ctrl: memory/consumer responders with programmable
// stalls, checked against a cycle-arithmetic model of each transaction.
module tb_tcp_tx_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int MAXC    = 200;

  typedef struct {
    int st_resp;
    int tp_resp;
    int calc;
    int pkt;
    int wr;
    int upd;
    int done;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] pkt_sent_cnt, pkt_suppressed_cnt;

  tcp_tx_ctrl_if bus_if();

  tcp_tx_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus_if.master),
    .pkt_sent_cnt       (pkt_sent_cnt),
    .pkt_suppressed_cnt (pkt_suppressed_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int model_sent = 0;
  int model_supp = 0;

  // per-transaction observations (cycle 0 = request accept cycle)
  int o_flowid_n, o_flowid_cyc, o_state_n, o_state_cyc, o_tuple_n, o_tuple_cyc;
  int o_calc_n, o_calc_cyc, o_streq_cyc, o_tpreq_cyc, o_stresp_cyc, o_tpresp_cyc;
  int o_pkt_n, o_pkt_cyc, o_wr_n, o_wr_cyc, o_upd_n, o_upd_cyc, o_pktval_n;
  int o_done_cyc, o_viol;
  bit o_timeout;
  logic [10:0] o_after_rst;
  logic        o_rdy_after_rst;

  // expected event cycles derived from stall/latency parameters
  function automatic exp_t model_txn(input int st_stall, tp_stall, st_lat, tp_lat,
                                     pkt_stall, wr_stall, upd_stall, input bit produce);
    exp_t e;
    int out0, last;
    e.st_resp = 1 + st_stall + st_lat;
    e.tp_resp = 1 + tp_stall + tp_lat;
    e.calc    = ((e.st_resp > e.tp_resp) ? e.st_resp : e.tp_resp) + 1;
    out0      = e.calc + 1;
    e.pkt     = produce ? out0 + pkt_stall : -1;
    e.wr      = out0 + wr_stall;
    e.upd     = out0 + upd_stall;
    last      = (e.wr > e.upd) ? e.wr : e.upd;
    if (e.pkt > last) last = e.pkt;
    e.done    = last + 1;
    return e;
  endfunction

  function automatic logic [10:0] outs_vec();
    return {bus_if.state_rd_req_val, bus_if.tuple_rd_req_val, bus_if.state_rd_resp_rdy,
            bus_if.tuple_rd_resp_rdy, bus_if.proto_calc_tx_pkt_val,
            bus_if.next_tx_state_wr_req_val, bus_if.tx_sched_update_val,
            bus_if.ctrl_datap_store_flowid, bus_if.ctrl_datap_store_state,
            bus_if.ctrl_datap_store_tuple, bus_if.ctrl_datap_store_calc};
  endfunction

  task automatic idle_inputs();
    bus_if.sched_tx_req_val         = 1'b0;
    bus_if.state_rd_req_rdy         = 1'b0;
    bus_if.state_rd_resp_val        = 1'b0;
    bus_if.tuple_rd_req_rdy         = 1'b0;
    bus_if.tuple_rd_resp_val        = 1'b0;
    bus_if.datap_ctrl_produce_pkt   = 1'b0;
    bus_if.next_tx_state_wr_req_rdy = 1'b0;
    bus_if.tx_sched_update_rdy      = 1'b0;
    bus_if.proto_calc_tx_pkt_rdy    = 1'b0;
  endtask

  task automatic run_txn(input int st_stall, tp_stall, st_lat, tp_lat,
                         pkt_stall, wr_stall, upd_stall, input bit produce,
                         input int abort_cyc);
    bit accepted, done;
    int st_seen, tp_seen, pk_seen, wr_seen, up_seen;
    logic [4:0] v, h, prev_v, prev_h;
    accepted = 0; done = 0;
    st_seen = 0; tp_seen = 0; pk_seen = 0; wr_seen = 0; up_seen = 0;
    prev_v = '0; prev_h = '0;
    o_flowid_n = 0; o_state_n = 0; o_tuple_n = 0; o_calc_n = 0;
    o_pkt_n = 0; o_wr_n = 0; o_upd_n = 0; o_pktval_n = 0; o_viol = 0;
    o_flowid_cyc = -1; o_state_cyc = -1; o_tuple_cyc = -1; o_calc_cyc = -1;
    o_streq_cyc = -1; o_tpreq_cyc = -1; o_stresp_cyc = -1; o_tpresp_cyc = -1;
    o_pkt_cyc = -1; o_wr_cyc = -1; o_upd_cyc = -1; o_done_cyc = -1;
    o_timeout = 0;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      @(negedge clk);
      bus_if.sched_tx_req_val         = !accepted;
      bus_if.datap_ctrl_produce_pkt   = produce;
      bus_if.state_rd_req_rdy         = (st_seen >= st_stall);
      bus_if.tuple_rd_req_rdy         = (tp_seen >= tp_stall);
      bus_if.state_rd_resp_val        = (o_streq_cyc >= 0) && (cyc >= o_streq_cyc + st_lat) && (o_stresp_cyc < 0);
      bus_if.tuple_rd_resp_val        = (o_tpreq_cyc >= 0) && (cyc >= o_tpreq_cyc + tp_lat) && (o_tpresp_cyc < 0);
      bus_if.proto_calc_tx_pkt_rdy    = (pk_seen >= pkt_stall);
      bus_if.next_tx_state_wr_req_rdy = (wr_seen >= wr_stall);
      bus_if.tx_sched_update_rdy      = (up_seen >= upd_stall);
      #1;
      if (accepted && bus_if.sched_tx_req_rdy) begin
        o_done_cyc = cyc;
        done = 1;
      end
      if (bus_if.sched_tx_req_val && bus_if.sched_tx_req_rdy) accepted = 1;
      if (bus_if.ctrl_datap_store_flowid) begin o_flowid_n++; o_flowid_cyc = cyc; end
      if (bus_if.ctrl_datap_store_state)  begin o_state_n++;  o_state_cyc  = cyc; end
      if (bus_if.ctrl_datap_store_tuple)  begin o_tuple_n++;  o_tuple_cyc  = cyc; end
      if (bus_if.ctrl_datap_store_calc)   begin o_calc_n++;   o_calc_cyc   = cyc; end
      if (bus_if.state_rd_resp_rdy && o_streq_cyc < 0) o_viol++;
      if (bus_if.tuple_rd_resp_rdy && o_tpreq_cyc < 0) o_viol++;
      v = {bus_if.state_rd_req_val, bus_if.tuple_rd_req_val, bus_if.proto_calc_tx_pkt_val,
           bus_if.next_tx_state_wr_req_val, bus_if.tx_sched_update_val};
      h = v & {bus_if.state_rd_req_rdy, bus_if.tuple_rd_req_rdy, bus_if.proto_calc_tx_pkt_rdy,
               bus_if.next_tx_state_wr_req_rdy, bus_if.tx_sched_update_rdy};
      if (|(prev_v & ~prev_h & ~v)) o_viol++;
      prev_v = v; prev_h = h;
      if (h[4] && o_streq_cyc < 0) o_streq_cyc = cyc;
      if (h[3] && o_tpreq_cyc < 0) o_tpreq_cyc = cyc;
      if (bus_if.state_rd_resp_val && bus_if.state_rd_resp_rdy) o_stresp_cyc = cyc;
      if (bus_if.tuple_rd_resp_val && bus_if.tuple_rd_resp_rdy) o_tpresp_cyc = cyc;
      if (h[2]) begin o_pkt_n++; o_pkt_cyc = cyc; end
      if (h[1]) begin o_wr_n++;  o_wr_cyc  = cyc; end
      if (h[0]) begin o_upd_n++; o_upd_cyc = cyc; end
      if (v[4]) st_seen++;
      if (v[3]) tp_seen++;
      if (v[2]) begin pk_seen++; o_pktval_n++; end
      if (v[1]) wr_seen++;
      if (v[0]) up_seen++;
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        o_after_rst     = outs_vec();
        o_rdy_after_rst = bus_if.sched_tx_req_rdy;
        idle_inputs();
        return;
      end
      if (done) break;
    end
    if (!done) o_timeout = 1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus_if.sched_tx_req_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", bus_if.sched_tx_req_rdy); end
    n_cmp++; if (outs_vec() !== 11'd0) begin n_err++; $display("FAIL reset_outs: got %b want 0", outs_vec()); end
    n_cmp++; if (pkt_sent_cnt !== '0 || pkt_suppressed_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", pkt_sent_cnt, pkt_suppressed_cnt); end
    rst_n = 1'b1;
    $display("reset: rdy=%b outs=%b", bus_if.sched_tx_req_rdy, outs_vec());
  endtask

  task automatic test_zero_wait();
    run_txn(0, 0, 1, 1, 0, 0, 0, 1'b1, -1);
    model_sent = (model_sent + 1) % CNT_MOD;
    $display("zero_wait: flowid@%0d st@%0d tp@%0d calc@%0d pkt@%0d wr@%0d upd@%0d done@%0d",
             o_flowid_cyc, o_state_cyc, o_tuple_cyc, o_calc_cyc, o_pkt_cyc, o_wr_cyc, o_upd_cyc, o_done_cyc);
    n_cmp++; if (o_timeout) begin n_err++; $display("FAIL zw_timeout: got timeout want done"); end
    n_cmp++; if (o_flowid_n != 1 || o_flowid_cyc != 0) begin n_err++; $display("FAIL zw_flowid: got n=%0d@%0d want 1@0", o_flowid_n, o_flowid_cyc); end
    n_cmp++; if (o_state_cyc != 2 || o_tuple_cyc != 2) begin n_err++; $display("FAIL zw_store: got st@%0d tp@%0d want 2/2", o_state_cyc, o_tuple_cyc); end
    n_cmp++; if (o_calc_n != 1 || o_calc_cyc != 3) begin n_err++; $display("FAIL zw_calc: got n=%0d@%0d want 1@3", o_calc_n, o_calc_cyc); end
    n_cmp++; if (o_pkt_cyc != 4 || o_wr_cyc != 4 || o_upd_cyc != 4) begin n_err++; $display("FAIL zw_out: got %0d/%0d/%0d want 4/4/4", o_pkt_cyc, o_wr_cyc, o_upd_cyc); end
    n_cmp++; if (o_done_cyc != 5) begin n_err++; $display("FAIL zw_done: got %0d want 5", o_done_cyc); end
    n_cmp++; if (pkt_sent_cnt !== CNT_W'(model_sent)) begin n_err++; $display("FAIL zw_sent: got %0d want %0d", pkt_sent_cnt, model_sent); end
  endtask

  task automatic test_no_pkt();
    run_txn(0, 0, 1, 1, 0, 0, 0, 1'b0, -1);
    model_supp = (model_supp + 1) % CNT_MOD;
    $display("no_pkt: pktval=%0d wr@%0d upd@%0d done@%0d supp=%0d", o_pktval_n, o_wr_cyc, o_upd_cyc, o_done_cyc, pkt_suppressed_cnt);
    n_cmp++; if (o_pktval_n != 0) begin n_err++; $display("FAIL np_pktval: got %0d cycles want 0", o_pktval_n); end
    n_cmp++; if (o_wr_cyc != 4 || o_upd_cyc != 4 || o_done_cyc != 5) begin n_err++; $display("FAIL np_out: got wr@%0d upd@%0d done@%0d want 4/4/5", o_wr_cyc, o_upd_cyc, o_done_cyc); end
    n_cmp++; if (pkt_suppressed_cnt !== CNT_W'(model_supp) || pkt_sent_cnt !== CNT_W'(model_sent)) begin n_err++; $display("FAIL np_cnt: got %0d/%0d want %0d/%0d", pkt_sent_cnt, pkt_suppressed_cnt, model_sent, model_supp); end
  endtask

  task automatic test_resp_order();
    exp_t e;
    e = model_txn(2, 0, 2, 1, 0, 0, 0, 1'b1);
    run_txn(2, 0, 2, 1, 0, 0, 0, 1'b1, -1);
    model_sent = (model_sent + 1) % CNT_MOD;
    $display("resp_order: tp@%0d st@%0d calc@%0d done@%0d", o_tpresp_cyc, o_stresp_cyc, o_calc_cyc, o_done_cyc);
    n_cmp++; if (o_state_n != 1 || o_tuple_n != 1 || o_calc_n != 1) begin n_err++; $display("FAIL ro_once: got %0d/%0d/%0d want 1/1/1", o_state_n, o_tuple_n, o_calc_n); end
    n_cmp++; if (o_tpresp_cyc != e.tp_resp || o_stresp_cyc != e.st_resp) begin n_err++; $display("FAIL ro_resp: got tp@%0d st@%0d want %0d/%0d", o_tpresp_cyc, o_stresp_cyc, e.tp_resp, e.st_resp); end
    n_cmp++; if (o_calc_cyc != e.calc) begin n_err++; $display("FAIL ro_calc: got %0d want %0d", o_calc_cyc, e.calc); end
    n_cmp++; if (o_viol != 0) begin n_err++; $display("FAIL ro_proto: got %0d violations want 0", o_viol); end
  endtask

  task automatic test_out_stall();
    exp_t e;
    e = model_txn(0, 0, 1, 1, 4, 0, 1, 1'b1);
    run_txn(0, 0, 1, 1, 4, 0, 1, 1'b1, -1);
    model_sent = (model_sent + 1) % CNT_MOD;
    $display("out_stall: pkt@%0d wr@%0d upd@%0d done@%0d", o_pkt_cyc, o_wr_cyc, o_upd_cyc, o_done_cyc);
    n_cmp++; if (o_pkt_cyc != e.pkt || o_wr_cyc != e.wr || o_upd_cyc != e.upd) begin n_err++; $display("FAIL os_hs: got %0d/%0d/%0d want %0d/%0d/%0d", o_pkt_cyc, o_wr_cyc, o_upd_cyc, e.pkt, e.wr, e.upd); end
    n_cmp++; if (o_pkt_n != 1 || o_wr_n != 1 || o_upd_n != 1) begin n_err++; $display("FAIL os_count: got %0d/%0d/%0d want 1/1/1", o_pkt_n, o_wr_n, o_upd_n); end
    n_cmp++; if (o_done_cyc != e.done) begin n_err++; $display("FAIL os_done: got %0d want %0d", o_done_cyc, e.done); end
    n_cmp++; if (o_viol != 0) begin n_err++; $display("FAIL os_hold: got %0d violations want 0", o_viol); end
  endtask

  task automatic test_abort();
    run_txn(0, 0, 1, 1, 10, 10, 10, 1'b1, 6);
    model_sent = 0; model_supp = 0;
    $display("abort: outs=%b rdy=%b wr_n=%0d upd_n=%0d cnt=%0d/%0d", o_after_rst, o_rdy_after_rst, o_wr_n, o_upd_n, pkt_sent_cnt, pkt_suppressed_cnt);
    n_cmp++; if (o_after_rst !== 11'd0) begin n_err++; $display("FAIL ab_outs: got %b want 0", o_after_rst); end
    n_cmp++; if (o_rdy_after_rst !== 1'b1) begin n_err++; $display("FAIL ab_rdy: got %b want 1", o_rdy_after_rst); end
    n_cmp++; if (o_wr_n != 0 || o_upd_n != 0) begin n_err++; $display("FAIL ab_emit: got wr=%0d upd=%0d want 0/0", o_wr_n, o_upd_n); end
    n_cmp++; if (pkt_sent_cnt !== '0 || pkt_suppressed_cnt !== '0) begin n_err++; $display("FAIL ab_cnt: got %0d/%0d want 0/0", pkt_sent_cnt, pkt_suppressed_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(0, 0, 1, 1, 0, 0, 0, 1'b1, -1);
    model_sent = (model_sent + 1) % CNT_MOD;
    $display("after_abort: flowid@%0d done@%0d sent=%0d", o_flowid_cyc, o_done_cyc, pkt_sent_cnt);
    n_cmp++; if (o_flowid_cyc != 0 || o_done_cyc != 5) begin n_err++; $display("FAIL ab_next: got flowid@%0d done@%0d want 0/5", o_flowid_cyc, o_done_cyc); end
    n_cmp++; if (pkt_sent_cnt !== CNT_W'(model_sent)) begin n_err++; $display("FAIL ab_sent: got %0d want %0d", pkt_sent_cnt, model_sent); end
  endtask

  task automatic test_random();
    exp_t e;
    int p[7];
    bit produce;
    for (int i = 0; i < 30; i++) begin
      p[0] = $urandom_range(0, 3); p[1] = $urandom_range(0, 3);
      p[2] = $urandom_range(1, 4); p[3] = $urandom_range(1, 4);
      p[4] = $urandom_range(0, 3); p[5] = $urandom_range(0, 3); p[6] = $urandom_range(0, 3);
      produce = 1'($urandom_range(0, 1));
      e = model_txn(p[0], p[1], p[2], p[3], p[4], p[5], p[6], produce);
      run_txn(p[0], p[1], p[2], p[3], p[4], p[5], p[6], produce, -1);
      if (produce) model_sent = (model_sent + 1) % CNT_MOD;
      else         model_supp = (model_supp + 1) % CNT_MOD;
      $display("rnd%0d: prod=%b st@%0d tp@%0d calc@%0d pkt@%0d wr@%0d upd@%0d done@%0d cnt=%0d/%0d",
               i, produce, o_stresp_cyc, o_tpresp_cyc, o_calc_cyc, o_pkt_cyc, o_wr_cyc, o_upd_cyc, o_done_cyc,
               pkt_sent_cnt, pkt_suppressed_cnt);
      n_cmp++; if (o_timeout) begin n_err++; $display("FAIL rnd%0d_timeout: got timeout want done", i); end
      n_cmp++; if (o_stresp_cyc != e.st_resp || o_tpresp_cyc != e.tp_resp) begin n_err++; $display("FAIL rnd%0d_resp: got %0d/%0d want %0d/%0d", i, o_stresp_cyc, o_tpresp_cyc, e.st_resp, e.tp_resp); end
      n_cmp++; if (o_state_cyc != e.st_resp || o_tuple_cyc != e.tp_resp || o_state_n != 1 || o_tuple_n != 1) begin n_err++; $display("FAIL rnd%0d_store: got %0d@%0d %0d@%0d want 1@%0d 1@%0d", i, o_state_n, o_state_cyc, o_tuple_n, o_tuple_cyc, e.st_resp, e.tp_resp); end
      n_cmp++; if (o_calc_n != 1 || o_calc_cyc != e.calc) begin n_err++; $display("FAIL rnd%0d_calc: got %0d@%0d want 1@%0d", i, o_calc_n, o_calc_cyc, e.calc); end
      n_cmp++; if (o_pkt_cyc != e.pkt || o_wr_cyc != e.wr || o_upd_cyc != e.upd) begin n_err++; $display("FAIL rnd%0d_out: got %0d/%0d/%0d want %0d/%0d/%0d", i, o_pkt_cyc, o_wr_cyc, o_upd_cyc, e.pkt, e.wr, e.upd); end
      n_cmp++; if (o_done_cyc != e.done) begin n_err++; $display("FAIL rnd%0d_done: got %0d want %0d", i, o_done_cyc, e.done); end
      n_cmp++; if (o_viol != 0) begin n_err++; $display("FAIL rnd%0d_proto: got %0d violations want 0", i, o_viol); end
      n_cmp++; if (pkt_sent_cnt !== CNT_W'(model_sent) || pkt_suppressed_cnt !== CNT_W'(model_supp)) begin n_err++; $display("FAIL rnd%0d_cnt: got %0d/%0d want %0d/%0d", i, pkt_sent_cnt, pkt_suppressed_cnt, model_sent, model_supp); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < CNT_MOD && model_sent != CNT_MOD - 1; i++) begin
      run_txn(0, 0, 1, 1, 0, 0, 0, 1'b1, -1);
      model_sent = (model_sent + 1) % CNT_MOD;
    end
    n_cmp++; if (pkt_sent_cnt !== CNT_W'(CNT_MOD - 1)) begin n_err++; $display("FAIL wrap_pre: got %0d want %0d", pkt_sent_cnt, CNT_MOD - 1); end
    run_txn(0, 0, 1, 1, 0, 0, 0, 1'b1, -1);
    model_sent = (model_sent + 1) % CNT_MOD;
    $display("wrap: sent=%0d supp=%0d", pkt_sent_cnt, pkt_suppressed_cnt);
    n_cmp++; if (pkt_sent_cnt !== '0) begin n_err++; $display("FAIL wrap: got %0d want 0", pkt_sent_cnt); end
    n_cmp++; if (pkt_suppressed_cnt !== CNT_W'(model_supp)) begin n_err++; $display("FAIL wrap_supp: got %0d want %0d", pkt_suppressed_cnt, model_supp); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_no_pkt();
    test_resp_order();
    test_out_stall();
    test_abort();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
